// File: rtl/perf_cnt_pkg.sv
// Shared types and helpers for the performance-counter read scheduler.
package perf_cnt_pkg;

    // Transaction FSM: waiting for a request, or presenting a response.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    // Default build-time configuration.
    localparam int DEF_CNT_W = 4;
    localparam int DEF_N_CNT = 4;
    localparam int DEF_N_REQ = 2;
    localparam int DEF_IDX_W = 2;

    // Round-robin pointer after a grant: the requester just above the winner,
    // wrapping back to zero past the last requester.
    function automatic int unsigned rr_next_ptr(input int unsigned grant,
                                                input int unsigned n_req);
        int unsigned nxt;
        if (grant + 32'd1 >= n_req) begin
            nxt = 32'd0;
        end else begin
            nxt = grant + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/perf_cnt_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first active
// request at or above the pointer, scanning upward with wrap-around.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_any
);

    logic            found_s;
    logic [ID_W-1:0] cand_s;

    // Priority scan starting at the pointer; first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = ID_W'((int'(ptr) + k) % N_REQ);
            if (!found_s && req[cand_s]) begin
                gnt[cand_s] = 1'b1;
                gnt_id      = cand_s;
                found_s     = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        gnt_any = found_s;
    end

endmodule

// File: rtl/perf_cnt_sched.sv
// Event counter bank with read-and-clear access shared by several software
// requesters. A round-robin arbiter picks one read at a time; the snapshot
// is returned on a valid/ready response channel one cycle after acceptance.
module perf_cnt_sched
    import perf_cnt_pkg::*;
#(
    parameter  int CNT_W = DEF_CNT_W,
    parameter  int N_CNT = DEF_N_CNT,
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int IDX_W = DEF_IDX_W,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_CNT-1:0]       evt_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ*IDX_W-1:0] req_idx_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic                   rsp_valid_o,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [CNT_W-1:0]       rsp_data_o,
    output logic                   rsp_ovf_o,
    input  logic                   rsp_ready_i
);

    state_e           state_r;
    state_e           state_nx_s;
    logic [ID_W-1:0]  ptr_r;
    logic [CNT_W-1:0] cnt_r [N_CNT];
    logic [N_CNT-1:0] ovf_r;

    logic [N_REQ-1:0] gnt_s;
    logic [ID_W-1:0]  gnt_id_s;
    logic             gnt_any_s;
    logic [N_REQ-1:0] req_ready_s;
    logic             accept_s;
    logic [IDX_W-1:0] acc_idx_s;
    logic             acc_hit_s;
    logic [CNT_W-1:0] acc_data_s;
    logic             acc_ovf_s;

    logic             rsp_valid_r;
    logic [ID_W-1:0]  rsp_id_r;
    logic [CNT_W-1:0] rsp_data_r;
    logic             rsp_ovf_r;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (req_valid_i),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_id  (gnt_id_s),
        .gnt_any (gnt_any_s)
    );

    // Grant is only offered while idle and out of reset.
    always_comb begin
        req_ready_s = '0;
        case (state_r)
            IDLE: begin
                if (reset_n && gnt_any_s) begin
                    req_ready_s = gnt_s;
                end else begin
                    req_ready_s = '0;
                end
            end
            RESP:    req_ready_s = '0;
            default: req_ready_s = '0;
        endcase
    end

    assign accept_s    = |(req_valid_i & req_ready_s);
    assign acc_idx_s   = req_idx_i[int'(gnt_id_s)*IDX_W +: IDX_W];
    assign acc_hit_s   = (int'(acc_idx_s) < N_CNT);
    assign req_ready_o = req_ready_s;

    // Snapshot of the selected counter; out-of-range indices read as zero.
    always_comb begin
        acc_data_s = '0;
        acc_ovf_s  = 1'b0;
        for (int i = 0; i < N_CNT; i++) begin
            if (acc_hit_s && (int'(acc_idx_s) == i)) begin
                acc_data_s = cnt_r[i];
                acc_ovf_s  = ovf_r[i];
            end else begin
                acc_data_s = acc_data_s;
                acc_ovf_s  = acc_ovf_s;
            end
        end
    end

    // Next-state: accept moves to RESP, consumer ready returns to IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Counter bank: count events, clear the accepted counter but keep the
    // event arriving in the clear cycle, and track sticky wrap flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CNT; i++) begin
                cnt_r[i] <= '0;
            end
            ovf_r <= '0;
        end else begin
            for (int i = 0; i < N_CNT; i++) begin
                if (accept_s && acc_hit_s && (int'(acc_idx_s) == i)) begin
                    cnt_r[i] <= CNT_W'(evt_i[i]);
                    ovf_r[i] <= 1'b0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(evt_i[i]);
                    if (evt_i[i] && (&cnt_r[i])) begin
                        ovf_r[i] <= 1'b1;
                    end else begin
                        ovf_r[i] <= ovf_r[i];
                    end
                end
            end
        end
    end

    // FSM state, round-robin pointer and registered response channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_data_r  <= '0;
            rsp_ovf_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            rsp_valid_r <= (state_nx_s == RESP);
            if (accept_s) begin
                ptr_r      <= ID_W'(rr_next_ptr(32'(gnt_id_s), 32'(N_REQ)));
                rsp_id_r   <= gnt_id_s;
                rsp_data_r <= acc_data_s;
                rsp_ovf_r  <= acc_ovf_s;
            end else begin
                ptr_r      <= ptr_r;
                rsp_id_r   <= rsp_id_r;
                rsp_data_r <= rsp_data_r;
                rsp_ovf_r  <= rsp_ovf_r;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_r;
    assign rsp_id_o    = rsp_id_r;
    assign rsp_data_o  = rsp_data_r;
    assign rsp_ovf_o   = rsp_ovf_r;

endmodule

// File: tb/tb_perf_cnt_sched.sv
// Directed bench for perf_cnt_sched (3 counters so index 3 is out of range).
// A cycle-level model tracks counters, the round-robin pointer and the
// pending response; it is checked on every falling edge, while the directed
// sequences add hand-computed literal expectations.
module tb_perf_cnt_sched;

    localparam int CNT_W = 4;
    localparam int N_CNT = 3;
    localparam int N_REQ = 2;
    localparam int IDX_W = 2;
    localparam int ID_W  = 1;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [N_CNT-1:0]       evt_i;
    logic [N_REQ-1:0]       req_valid_i;
    logic [N_REQ*IDX_W-1:0] req_idx_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic                   rsp_valid_o;
    logic [ID_W-1:0]        rsp_id_o;
    logic [CNT_W-1:0]       rsp_data_o;
    logic                   rsp_ovf_o;
    logic                   rsp_ready_i;

    int n_vec = 0;
    int n_err = 0;

    perf_cnt_sched #(
        .CNT_W (CNT_W),
        .N_CNT (N_CNT),
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .evt_i       (evt_i),
        .req_valid_i (req_valid_i),
        .req_idx_i   (req_idx_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_ovf_o   (rsp_ovf_o),
        .rsp_ready_i (rsp_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt [N_CNT];
    int m_ovf [N_CNT];
    int m_ptr;
    int m_busy;
    int m_id, m_data, m_ovfo;

    // Falling edge: compare against the model, then advance the model by
    // the effect of the coming rising edge using the inputs now applied.
    initial begin
        int exp_g, exp_ready, sel_idx, t, r;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                for (int i = 0; i < N_CNT; i++) begin
                    m_cnt[i] = 0;
                    m_ovf[i] = 0;
                end
                m_ptr = 0; m_busy = 0; m_id = 0; m_data = 0; m_ovfo = 0;
                chk("rst_ready", int'(req_ready_o), 0);
                chk("rst_valid", int'(rsp_valid_o), 0);
                chk("rst_id", int'(rsp_id_o), 0);
                chk("rst_data", int'(rsp_data_o), 0);
                chk("rst_ovf", int'(rsp_ovf_o), 0);
            end else begin
                exp_g = -1;
                if (m_busy == 0) begin
                    for (int k = 0; k < N_REQ; k++) begin
                        r = (m_ptr + k) % N_REQ;
                        if (exp_g < 0 && req_valid_i[r]) exp_g = r;
                    end
                end
                exp_ready = (exp_g >= 0) ? (1 << exp_g) : 0;
                chk("ready", int'(req_ready_o), exp_ready);
                chk("rsp_valid", int'(rsp_valid_o), m_busy);
                if (m_busy != 0) begin
                    chk("rsp_id", int'(rsp_id_o), m_id);
                    chk("rsp_data", int'(rsp_data_o), m_data);
                    chk("rsp_ovf", int'(rsp_ovf_o), m_ovfo);
                end
                sel_idx = -1;
                if (m_busy != 0) begin
                    if (rsp_ready_i) m_busy = 0;
                end else if (exp_g >= 0) begin
                    sel_idx = int'(req_idx_i[exp_g*IDX_W +: IDX_W]);
                    m_busy  = 1;
                    m_id    = exp_g;
                    m_data  = (sel_idx < N_CNT) ? m_cnt[sel_idx] : 0;
                    m_ovfo  = (sel_idx < N_CNT) ? m_ovf[sel_idx] : 0;
                    m_ptr   = (exp_g + 1) % N_REQ;
                end
                for (int i = 0; i < N_CNT; i++) begin
                    if (sel_idx == i) begin
                        m_cnt[i] = int'(evt_i[i]);
                        m_ovf[i] = 0;
                    end else begin
                        t = m_cnt[i] + int'(evt_i[i]);
                        if (t >= (1 << CNT_W)) begin
                            m_ovf[i] = 1;
                            t = t - (1 << CNT_W);
                        end
                        m_cnt[i] = t;
                    end
                end
            end
        end
    end

    // One read: wait for the grant (bounded), hold evt for the accept
    // cycle, then check the response one cycle after acceptance.
    task automatic read_chk(input int r, input int idx, input logic [N_CNT-1:0] evt,
                            input int exp_data, input int exp_ovf);
        int n;
        n = 0;
        tick();
        req_valid_i[r] = 1'b1;
        req_idx_i[r*IDX_W +: IDX_W] = IDX_W'(idx);
        evt_i = evt;
        #1;
        while (!req_ready_o[r] && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk("grant_seen", int'(req_ready_o[r]), 1);
        tick();
        req_valid_i[r] = 1'b0;
        evt_i = '0;
        chk("lit_valid", int'(rsp_valid_o), 1);
        chk("lit_id", int'(rsp_id_o), r);
        chk("lit_data", int'(rsp_data_o), exp_data);
        chk("lit_ovf", int'(rsp_ovf_o), exp_ovf);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int ids[$];
        reset_n = 1'b0;
        evt_i = '0;
        req_valid_i = '0;
        req_idx_i = '0;
        rsp_ready_i = 1'b1;
        repeat (3) tick();
        req_valid_i = 2'b11;
        #1;
        chk("reset_ready_gated", int'(req_ready_o), 0);
        chk("reset_valid", int'(rsp_valid_o), 0);
        req_valid_i = '0;
        reset_n = 1'b1;

        // Basic: 5 events on counter 1, read then re-read
        tick();
        evt_i = 3'b010;
        repeat (5) tick();
        evt_i = '0;
        read_chk(0, 1, 3'b000, 5, 0);
        read_chk(0, 1, 3'b000, 0, 0);

        // Event during the clear cycle seeds the cleared counter
        tick();
        evt_i = 3'b100;
        repeat (3) tick();
        evt_i = '0;
        read_chk(1, 2, 3'b100, 3, 0);
        read_chk(1, 2, 3'b000, 1, 0);

        // Wrap: 17 events on a 4-bit counter
        tick();
        evt_i = 3'b001;
        repeat (17) tick();
        evt_i = '0;
        read_chk(1, 0, 3'b000, 1, 1);
        read_chk(1, 0, 3'b000, 0, 0);

        // Arbitration: both requesters valid continuously
        tick();
        req_idx_i = {2'd2, 2'd1};
        req_valid_i = 2'b11;
        repeat (8) begin
            tick();
            if (rsp_valid_o) ids.push_back(int'(rsp_id_o));
        end
        req_valid_i = '0;
        chk("arb_count", ids.size(), 4);
        for (int k = 0; k < ids.size() && k < 4; k++) chk("arb_id", ids[k], k % 2);

        // Backpressure: response held stable, no grants while pending
        tick();
        evt_i = 3'b010;
        repeat (2) tick();
        evt_i = '0;
        rsp_ready_i = 1'b0;
        req_valid_i = 2'b01;
        req_idx_i = {2'd0, 2'd1};
        tick();
        req_valid_i = 2'b10;
        repeat (4) begin
            #1;
            chk("bp_valid", int'(rsp_valid_o), 1);
            chk("bp_data", int'(rsp_data_o), 2);
            chk("bp_id", int'(rsp_id_o), 0);
            chk("bp_ready", int'(req_ready_o), 0);
            tick();
        end
        rsp_ready_i = 1'b1;
        req_valid_i = '0;
        // Out-of-range index: zero data, no counter touched
        read_chk(1, 3, 3'b111, 0, 0);
        read_chk(0, 0, 3'b000, 1, 0);

        // Reset while a response is pending
        tick();
        rsp_ready_i = 1'b0;
        req_valid_i = 2'b10;
        req_idx_i = {2'd2, 2'd0};
        tick();
        req_valid_i = '0;
        #1;
        chk("pre_rst_valid", int'(rsp_valid_o), 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(rsp_valid_o), 0);
        chk("async_rst_data", int'(rsp_data_o), 0);
        tick();
        tick();
        reset_n = 1'b1;
        rsp_ready_i = 1'b1;
        req_valid_i = 2'b11;
        req_idx_i = {2'd1, 2'd0};
        #1;
        chk("post_rst_grant", int'(req_ready_o), 1);
        tick();
        req_valid_i = '0;
        chk("post_rst_id", int'(rsp_id_o), 0);
        chk("post_rst_data", int'(rsp_data_o), 0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/perf_cnt_sched.md
Name: perf_cnt_sched

Overview:
- Bank of N_CNT event counters, read-and-clear access shared among N_REQ software requesters.
- Round-robin arbiter selects one requester's read; a small FSM then returns the snapshot over a valid/ready response channel.
- Sits between CPU trigger sources (events in) and per-agent software ports; sequences each counter's clear and readout, one transaction at a time.

Parameters:
- CNT_W, 4, counter width in bits
- N_CNT, 4, number of event counters
- N_REQ, 2, number of software requesters
- IDX_W, 2, counter index width; must satisfy 2^IDX_W >= N_CNT

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- evt_i  in  N_CNT  per-counter event pulse; counts +1 per cycle high
- req_valid_i  in  N_REQ  read-and-clear request per requester
- req_idx_i  in  N_REQ*IDX_W  counter index; requester r uses bits [r*IDX_W +: IDX_W]
- req_ready_o  out  N_REQ  one-hot grant; request accepted when valid&&ready
- rsp_valid_o  out  1  response valid
- rsp_id_o  out  $clog2(N_REQ) (min 1)  granted requester id
- rsp_data_o  out  CNT_W  counter snapshot
- rsp_ovf_o  out  1  counter wrapped since its last clear
- rsp_ready_i  in  1  response consumer ready

Behaviour:
- Reset (async assert, sync deassert by clock): all counters = 0; ovf flags = 0; RR pointer = 0; state = IDLE; rsp_valid_o = 0, rsp_id_o = 0, rsp_data_o = 0, rsp_ovf_o = 0; req_ready_o = 0.
- Counting: every cycle, cnt[i] <= cnt[i] + evt_i[i], wrapping modulo 2^CNT_W. A wrap (all-ones + 1) sets sticky ovf[i].
- FSM states: IDLE, RESP.
- IDLE:
  - req_ready_o is combinational: one-hot for the first valid requester at or after the RR pointer, scanning upward with wrap.
  - On handshake: latch id, data = cnt[idx], ovf = ovf[idx]. Same edge, cnt[idx] <= evt_i[idx] (event in clear cycle counted, not lost), ovf[idx] <= 0. RR pointer <= grant+1 mod N_REQ. Go to RESP.
- RESP:
  - rsp_valid_o = 1; id, data and ovf held stable.
  - req_ready_o = 0 (no new accepts).
  - On rsp_ready_i, go to IDLE; a new grant is possible the next cycle.
- Latency: rsp_valid_o rises exactly 1 cycle after accept. Minimum turnaround is 2 cycles per transaction (accept, respond/consume).
- Snapshot excludes the event in the accept cycle; that event seeds the cleared counter.
- Index >= N_CNT: accepted normally; response data = 0, ovf = 0; no counter modified.
- Simultaneous requests: only one grant per accept. Losers keep valid asserted and are served in RR order. Starvation-free: max wait (N_REQ-1) transactions.
- Requester must hold valid and idx stable until ready (protocol rule; the block does not check it).
- Counters keep counting in RESP; only the accepted counter's clear is affected.
- Reset mid-transaction: pending response dropped; all state returns to reset values.

Decomposition:
- Package perf_cnt_pkg:
  - state enum {IDLE, RESP}
  - default parameter constants
  - function for the RR next-pointer
- Sub-module rr_arbiter (N_REQ, combinational one-hot grant from req vector + pointer) is natural; the pointer register stays in perf_cnt_sched.

Test Plan:
- Basic: evt_i[1] high 5 cycles, then req r0 idx=1 with evt_i[1]=0 → rsp_data=5, ovf=0, id=0 one cycle after accept; re-read → 0.
- Clear-cycle event: cnt[2]=3, accept idx=2 with evt_i[2]=1 → rsp_data=3; immediate re-read (no further events) → 1.
- Wrap: 17 events on cnt[0] (CNT_W=4), read → data=1, ovf=1; re-read → data=0, ovf=0.
- Arbitration: r0 and r1 both valid continuously, rsp_ready_i=1 → grants alternate r0,r1,r0,r1; rsp_id_o sequence 0,1,0,1.
- Backpressure: rsp_ready_i=0 for 4 cycles → rsp_valid_o, data and id held stable, req_ready_o=0 throughout; release → IDLE next cycle; invalid idx=3 with N_CNT=3 → data=0, no counters changed.
- Reset: assert reset_n=0 while in RESP → rsp_valid_o=0 immediately, counters 0; after release, first grant goes to r0.
